scan_serial_io: RTL and testbench

SCAN_SERIAL_IO -- requirements
Module: scan_serial_io

---
 rtl/scan_serial_io.sv | 152 +++++++++++++++
 tb/tb_scan_serial_io.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_serial_io.sv
// scan_serial_io: scan chain with capture/update shadow register plus an
// independent serial readout engine that streams latched words MSB first.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit
// after every readout word.
module scan_serial_io #(
  parameter int unsigned SC_LEN   = 395,
  parameter int unsigned CAP_W    = 48,
  parameter int unsigned RD_WORDS = 3,
  parameter int unsigned RD_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic                         scan_in,
  output logic                         scan_out,
  input  logic                         update,
  input  logic                         capture,
  input  logic [CAP_W-1:0]             cap_data,
  output logic [SC_LEN-1:0]            cfg_q,
  input  logic                         rd_req,
  input  logic [RD_WORDS*RD_WIDTH-1:0] rd_data,
  output logic                         serial_out,
  output logic                         serial_valid,
  output logic                         rd_busy,
  output logic                         rd_done
);

  localparam int unsigned BufW    = RD_WORDS * RD_WIDTH;
  localparam int unsigned MaxBits = RD_WORDS * (RD_WIDTH + 1);
  localparam int unsigned CntW    = $clog2(MaxBits + 1);
`ifdef SERIAL_PARITY_EN
  localparam int unsigned NumBits = MaxBits;
  localparam int unsigned PosW    = $clog2(RD_WIDTH + 1);
`else
  localparam int unsigned NumBits = BufW;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBits - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} rd_state_e;

  logic [SC_LEN-1:0] sr_q;
  rd_state_e         state_q, state_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_PARITY_EN
  logic [PosW-1:0]   pos_q, pos_d;
  logic              par_q, par_d;
`endif

  assign scan_out = sr_q[SC_LEN-1];

  // Scan register: capture wins over shift; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (capture) begin
      sr_q[SC_LEN-1 -: CAP_W] <= cap_data;
    end else if (shift_en) begin
      sr_q <= {sr_q[SC_LEN-2:0], scan_in};
    end
  end

  // Shadow register samples the pre-edge scan contents on update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (update) begin
      cfg_q <= sr_q;
    end
  end

  // Readout state, buffer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_PARITY_EN
      pos_q   <= '0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_PARITY_EN
      pos_q   <= pos_d;
      par_q   <= par_d;
`endif
    end
  end

  // Readout next-state and outputs; the buffer shifts left so its MSB is always the next data bit.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    rd_busy      = 1'b0;
    rd_done      = 1'b0;
`ifdef SERIAL_PARITY_EN
    pos_d        = pos_q;
    par_d        = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d = StShift;
          buf_d   = rd_data;
          cnt_d   = '0;
`ifdef SERIAL_PARITY_EN
          pos_d   = '0;
          par_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        serial_valid = 1'b1;
        rd_busy      = 1'b1;
        cnt_d        = cnt_q + CntW'(1);
`ifdef SERIAL_PARITY_EN
        // Slot RD_WIDTH of each word carries the accumulated parity.
        if (pos_q == PosW'(RD_WIDTH)) begin
          serial_out = par_q;
          pos_d      = '0;
          par_d      = 1'b0;
        end else begin
          serial_out = buf_q[BufW-1];
          buf_d      = buf_q << 1;
          par_d      = par_q ^ buf_q[BufW-1];
          pos_d      = pos_q + PosW'(1);
        end
`else
        serial_out = buf_q[BufW-1];
        buf_d      = buf_q << 1;
`endif
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rd_done = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_serial_io.sv
// Directed + randomized bench for scan_serial_io; the readout stream is
// predicted from the word list with a bit queue, the scan image from whole vectors.
module tb_scan_serial_io;

  localparam int unsigned SC_LEN   = 395;
  localparam int unsigned CAP_W    = 48;
  localparam int unsigned RD_WORDS = 3;
  localparam int unsigned RD_WIDTH = 16;
  localparam int unsigned RDW      = RD_WORDS * RD_WIDTH;

  logic              clk = 1'b0;
  logic              rst, shift_en, scan_in, scan_out, update, capture;
  logic [CAP_W-1:0]  cap_data;
  logic [SC_LEN-1:0] cfg_q;
  logic              rd_req;
  logic [RDW-1:0]    rd_data;
  logic              serial_out, serial_valid, rd_busy, rd_done;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  logic [SC_LEN-1:0] img, img2, expv;
  logic [RDW-1:0]    d0;

  always #5 clk = ~clk;

  scan_serial_io #(
    .SC_LEN  (SC_LEN),
    .CAP_W   (CAP_W),
    .RD_WORDS(RD_WORDS),
    .RD_WIDTH(RD_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .update      (update),
    .capture     (capture),
    .cap_data    (cap_data),
    .cfg_q       (cfg_q),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .rd_busy     (rd_busy),
    .rd_done     (rd_done)
  );

  task automatic chk(input string tag, input logic [SC_LEN-1:0] obs, input logic [SC_LEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected serial stream: words in order, MSB first, optional even parity after each.
  task automatic build(input logic [RDW-1:0] d);
    logic [RD_WIDTH-1:0] w;
    exp_q.delete();
    for (int k = 0; k < int'(RD_WORDS); k++) begin
      w = d[RDW-1-k*RD_WIDTH -: RD_WIDTH];
      for (int b = RD_WIDTH - 1; b >= 0; b--) exp_q.push_back(w[b]);
`ifdef SERIAL_PARITY_EN
      exp_q.push_back(^w);
`endif
    end
  endtask

  function automatic logic [SC_LEN-1:0] rand_vec();
    logic [SC_LEN-1:0] v;
    for (int k = 0; k < int'(SC_LEN); k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Shift a full image in, MSB first; optionally check the old contents emerging on scan_out.
  task automatic shift_vec(input logic [SC_LEN-1:0] v, input bit check_out,
                           input logic [SC_LEN-1:0] old);
    for (int k = int'(SC_LEN) - 1; k >= 0; k--) begin
      if (check_out) chk("scan_out_stream", scan_out, old[k]);
      shift_en = 1'b1;
      scan_in  = v[k];
      @(negedge clk);
    end
    shift_en = 1'b0;
    scan_in  = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic start_rd(input logic [RDW-1:0] d);
    chk("idle_busy", rd_busy, 0);
    rd_data = d;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req  = 1'b0;
    rd_data = {$urandom, $urandom};
  endtask

  // Check a complete stream plus DONE timing; optionally re-pulse rd_req at a bit index.
  task automatic collect(input int repulse_at, input logic [RDW-1:0] d2);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("bit_valid", serial_valid, 1);
      chk("bit_busy", rd_busy, 1);
      chk("bit_done_low", rd_done, 0);
      chk($sformatf("bit%0d", i), serial_out, exp_q[i]);
      if (i == repulse_at) begin
        rd_req  = 1'b1;
        rd_data = d2;
      end else begin
        rd_req = 1'b0;
      end
      @(negedge clk);
    end
    rd_req = 1'b0;
    chk("done_pulse", rd_done, 1);
    chk("done_valid", serial_valid, 0);
    chk("done_busy", rd_busy, 0);
    chk("done_out", serial_out, 0);
    @(negedge clk);
    chk("post_done", rd_done, 0);
    chk("post_busy", rd_busy, 0);
    chk("post_valid", serial_valid, 0);
  endtask

  initial begin
    rst = 1'b1; shift_en = 1'b0; scan_in = 1'b0; update = 1'b0; capture = 1'b0;
    cap_data = '0; rd_req = 1'b0; rd_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cfg", cfg_q, '0);
    chk("rst_scan_out", scan_out, 0);
    chk("rst_out", serial_out, 0);
    chk("rst_valid", serial_valid, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_done", rd_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Shift-in and update.
    img = rand_vec();
    shift_vec(img, 1'b1, '0);
    chk("scan_out_top", scan_out, img[SC_LEN-1]);
    chk("cfg_before_update", cfg_q, '0);
    do_update();
    chk("cfg_image", cfg_q, img);

    // Capture beats shift; update sees the pre-edge contents.
    cap_data = 48'h0BBB178B1DD5;
    capture = 1'b1; shift_en = 1'b1; update = 1'b1; scan_in = 1'b1;
    @(negedge clk);
    capture = 1'b0; shift_en = 1'b0; update = 1'b0; scan_in = 1'b0;
    chk("prio_cfg_pre", cfg_q, img);
    chk("prio_scan_out", scan_out, cap_data[CAP_W-1]);
    repeat (3) @(negedge clk);
    chk("cfg_hold", cfg_q, img);
    do_update();
    expv = {cap_data, img[SC_LEN-CAP_W-1:0]};
    chk("prio_cfg_post", cfg_q, expv);

    // Directed readout.
    d0 = {16'h1771, 16'h17A4, 16'h0019};
    build(d0);
    start_rd(d0);
    collect(-1, '0);

    // Ignored re-request with different data.
    build(d0);
    start_rd(d0);
    collect(10, ~d0);

    // Random readouts with concurrent scan shifting.
    for (int t = 0; t < 3; t++) begin
      d0   = {$urandom, $urandom};
      img2 = rand_vec();
      build(d0);
      fork
        shift_vec(img2, 1'b1, expv);
        begin
          start_rd(d0);
          collect(-1, '0);
        end
      join
      do_update();
      chk("concurrent_cfg", cfg_q, img2);
      expv = img2;
    end

    // Abort at bit 20.
    d0 = {$urandom, $urandom};
    build(d0);
    start_rd(d0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("abort_bit%0d", i), serial_out, exp_q[i]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", serial_valid, 0);
    chk("abort_busy", rd_busy, 0);
    chk("abort_done", rd_done, 0);
    chk("abort_cfg", cfg_q, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", rd_done, 0);
    end
    d0 = {$urandom, $urandom};
    build(d0);
    start_rd(d0);
    collect(-1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
